// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus plus registered register-file write port.
// Requesters/bench use the master modport; the arbiter uses the slave modport.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               stall;
    logic               wen;
    logic [AW-1:0]      wadd;
    logic [DW-1:0]      wdi;
    logic [1:0]         grant_id;
    logic               conflict;
    logic [15:0]        drop_cnt;

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, wen, wadd, wdi, grant_id, conflict, drop_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, wen, wadd, wdi, grant_id, conflict, drop_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port; gates r0, flags collisions.
// Latency: 1 cycle from grant to wen/wadd/wdi.
// Backpressure: stall forces all req_ready low; losers stay pending until granted.
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 res_n,
    regfile_wr_arbiter_if.slave  bus
);

    logic [1:0]      last;
    logic [3:0]      valid_ext;
    logic            gnt_any;
    logic [1:0]      gnt_idx;
    logic [2:0]      probe;
    logic            arb_en;
    logic [NREQ-1:0] ready_vec;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            hit;

    logic            wen_q;
    logic [AW-1:0]   wadd_q;
    logic [DW-1:0]   wdi_q;
    logic [1:0]      grant_id_q;
    logic            conflict_q;
    logic [15:0]     drop_cnt_q;

    assign valid_ext = 4'(bus.req_valid);

    // Search last+1, last+2, ... wrapping at NREQ; first valid index wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last;
        probe   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            probe = {1'b0, last} + 3'(k);
            if (probe >= 3'(NREQ)) begin
                probe = probe - 3'(NREQ);
            end
            if (!gnt_any && valid_ext[probe[1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = probe[1:0];
            end
        end
    end

    // Ready is held low throughout reset so no transfer can be seen by a requester.
    assign arb_en    = res_n && !bus.stall && gnt_any;
    assign ready_vec = arb_en ? (NREQ'(1) << gnt_idx) : '0;
    assign xfer      = |(bus.req_valid & ready_vec);
    assign sel_addr  = bus.req_addr[gnt_idx*AW +: AW];
    assign sel_data  = bus.req_data[gnt_idx*DW +: DW];

    // Collision check looks at raw valids, so it runs even while stalled.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (bus.req_valid[i] && bus.req_valid[j] &&
                    (bus.req_addr[i*AW +: AW] == bus.req_addr[j*AW +: AW]) &&
                    (bus.req_addr[i*AW +: AW] != '0)) begin
                    hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            last       <= 2'(NREQ - 1);
            wen_q      <= 1'b0;
            wadd_q     <= '0;
            wdi_q      <= '0;
            grant_id_q <= '0;
            conflict_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            conflict_q <= hit;
            wen_q      <= 1'b0;
            if (xfer) begin
                last       <= gnt_idx;
                grant_id_q <= gnt_idx;
                if (sel_addr != '0) begin
                    wen_q  <= 1'b1;
                    wadd_q <= sel_addr;
                    wdi_q  <= sel_data;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.wen       = wen_q;
    assign bus.wadd      = wadd_q;
    assign bus.wdi       = wdi_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.conflict  = conflict_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector bench for regfile_wr_arbiter (NREQ=3, AW=5, DW=32).
module tb_regfile_wr_arbiter;

    logic clk;
    logic res_n;
    int   checks;
    int   failures;

    regfile_wr_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

    regfile_wr_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          stall;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  rdy;
        logic        wen;
        logic [4:0]  wadd;
        logic [31:0] wdi;
        logic [1:0]  gid;
        logic        conf;
        logic [15:0] drop;
    } vec_t;

    localparam logic [31:0] DA = 32'hAAAA_0005;
    localparam logic [31:0] DB = 32'hBBBB_0005;

    function automatic vec_t mk(bit rst, bit stall, logic [2:0] valid,
                                logic [4:0] a2, logic [4:0] a1, logic [4:0] a0,
                                logic [31:0] d2, logic [31:0] d1, logic [31:0] d0,
                                logic [2:0] rdy, logic wen, logic [4:0] wadd,
                                logic [31:0] wdi, logic [1:0] gid, logic conf,
                                logic [15:0] drop);
        vec_t v;
        v.rst = rst; v.stall = stall; v.valid = valid;
        v.addr = {a2, a1, a0};
        v.data = {d2, d1, d0};
        v.rdy = rdy; v.wen = wen; v.wadd = wadd; v.wdi = wdi;
        v.gid = gid; v.conf = conf; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit stall, input logic [2:0] valid,
                         input logic [14:0] addr, input logic [95:0] data);
        bus.stall     = stall;
        bus.req_valid = valid;
        bus.req_addr  = addr;
        bus.req_data  = data;
    endtask

    // Hold reset across two edges, confirm reset state, release on a falling edge.
    task automatic do_reset();
        res_n = 1'b0;
        drive(1'b0, 3'b000, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_wen", 32'(bus.wen), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        res_n = 1'b1;
    endtask

    vec_t vt[19];

    initial begin
        checks   = 0;
        failures = 0;
        res_n    = 1'b0;
        drive(1'b0, 3'b000, '0, '0);

        vt[0]  = mk(1, 0, 3'b010, 0, 8, 0, 0, 32'hDEADBEEF, 0, 3'b010, 1, 8, 32'hDEADBEEF, 1, 0, 0);
        vt[1]  = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,            3'b000, 0, 8, 32'hDEADBEEF, 1, 0, 0);
        vt[2]  = mk(1, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b001, 1, 1, 32'h11, 0, 0, 0);
        vt[3]  = mk(0, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b010, 1, 2, 32'h22, 1, 0, 0);
        vt[4]  = mk(0, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b100, 1, 3, 32'h33, 2, 0, 0);
        vt[5]  = mk(0, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b001, 1, 1, 32'h11, 0, 0, 0);
        vt[6]  = mk(0, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b010, 1, 2, 32'h22, 1, 0, 0);
        vt[7]  = mk(0, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b100, 1, 3, 32'h33, 2, 0, 0);
        vt[8]  = mk(0, 1, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 0, 3, 32'h33, 2, 0, 0);
        vt[9]  = mk(0, 1, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 0, 3, 32'h33, 2, 0, 0);
        vt[10] = mk(0, 1, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 0, 3, 32'h33, 2, 0, 0);
        vt[11] = mk(0, 0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b001, 1, 1, 32'h11, 0, 0, 0);
        vt[12] = mk(1, 0, 3'b011, 0, 5, 5, 0, DB, DA, 3'b001, 1, 5, DA, 0, 1, 0);
        vt[13] = mk(0, 0, 3'b010, 0, 5, 5, 0, DB, DA, 3'b010, 1, 5, DB, 1, 0, 0);
        vt[14] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,   3'b000, 0, 5, DB, 1, 0, 0);
        vt[15] = mk(0, 0, 3'b011, 0, 0, 0, 0, 2, 1,   3'b001, 0, 5, DB, 0, 0, 1);
        vt[16] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,   3'b000, 0, 5, DB, 0, 0, 1);
        vt[17] = mk(0, 1, 3'b101, 7, 0, 7, 0, 0, 0,   3'b000, 0, 5, DB, 0, 1, 1);
        vt[18] = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,   3'b000, 0, 5, DB, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            if (vt[i].rst) do_reset();
            drive(vt[i].stall, vt[i].valid, vt[i].addr, vt[i].data);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vt[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", i), 32'(bus.wen), 32'(vt[i].wen));
            chk($sformatf("v%0d_wadd", i), 32'(bus.wadd), 32'(vt[i].wadd));
            chk($sformatf("v%0d_wdi", i), bus.wdi, vt[i].wdi);
            chk($sformatf("v%0d_gid", i), 32'(bus.grant_id), 32'(vt[i].gid));
            chk($sformatf("v%0d_conf", i), 32'(bus.conflict), 32'(vt[i].conf));
            chk($sformatf("v%0d_drop", i), 32'(bus.drop_cnt), 32'(vt[i].drop));
            @(negedge clk);
        end

        // r0 writes from requester 2: accepted, never enabled, counted, then saturated.
        do_reset();
        drive(1'b0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'h0, 32'h0});
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("r0_ready%0d", i), 32'(bus.req_ready), 32'h4);
            @(posedge clk);
            #1;
            chk($sformatf("r0_wen%0d", i), 32'(bus.wen), 32'd0);
            @(negedge clk);
        end
        chk("r0_drop5", 32'(bus.drop_cnt), 32'd5);
        chk("r0_wadd_hold", 32'(bus.wadd), 32'd0);
        for (int i = 0; i < 65535; i++) @(negedge clk);
        chk("r0_drop_sat", 32'(bus.drop_cnt), 32'hFFFF);
        chk("r0_gid", 32'(bus.grant_id), 32'd2);

        // Asynchronous reset mid-cycle while a write and a collision are registered.
        do_reset();
        drive(1'b0, 3'b001, '0, '0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'b110, {5'd9, 5'd9, 5'd0}, {32'hC2, 32'hC1, 32'h0});
        @(posedge clk);
        #1;
        chk("ar_pre_wen", 32'(bus.wen), 32'd1);
        chk("ar_pre_gid", 32'(bus.grant_id), 32'd1);
        chk("ar_pre_conf", 32'(bus.conflict), 32'd1);
        chk("ar_pre_drop", 32'(bus.drop_cnt), 32'd1);
        #2;
        res_n = 1'b0;
        #1;
        chk("ar_wen", 32'(bus.wen), 32'd0);
        chk("ar_wadd", 32'(bus.wadd), 32'd0);
        chk("ar_wdi", bus.wdi, 32'd0);
        chk("ar_gid", 32'(bus.grant_id), 32'd0);
        chk("ar_conf", 32'(bus.conflict), 32'd0);
        chk("ar_drop", 32'(bus.drop_cnt), 32'd0);
        chk("ar_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        res_n = 1'b1;
        #1;
        chk("ar_post_ready", 32'(bus.req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("ar_post_gid", 32'(bus.grant_id), 32'd1);
        chk("ar_post_wadd", 32'(bus.wadd), 32'd9);
        chk("ar_post_wdi", bus.wdi, 32'hC1);
        @(negedge clk);
        drive(1'b0, 3'b000, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
